clk_rst_gen: RTL

Synthesizable, parametrised successor to the free-running clock/reset model. It derives NUM_CH divided clocks from one system clock. Each channel has a runtime-programmable ratio with glitch-free reload. It also sequences per-channel active-low reset releases in a fixed, staggered order. It sits at the top of the SPI subsystem and feeds the SPI core and peripheral models.

---
 rtl/clk_rst_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/clk_rst_gen.sv
// Divided-clock generator with glitch-free ratio reload and a staggered per-channel reset sequencer.
// Optional CLK_RST_GEN_SOFT_RST_EN adds a synchronous soft_rst input that restarts the sequencer only.
module clk_rst_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DIV_RST     = 4,
  parameter int RST_HOLD    = 16,
  parameter int RST_STAGGER = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic                    cfg_load,
`ifdef CLK_RST_GEN_SOFT_RST_EN
  input  logic                    soft_rst,
`endif
  output logic [NUM_CH-1:0]       clk_div,
  output logic [NUM_CH-1:0]       clk_stb,
  output logic [NUM_CH-1:0]       rstn_out,
  output logic                    rst_done
);

  localparam int SEQ_MAX = (RST_HOLD > RST_STAGGER) ? RST_HOLD : RST_STAGGER;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_CH + 1);

  localparam logic [SEQ_W-1:0] HOLD_LAST    = SEQ_W'(RST_HOLD - 1);
  localparam logic [SEQ_W-1:0] STAGGER_LAST = SEQ_W'(RST_STAGGER - 1);
  localparam logic [IDX_W-1:0] ALL_REL      = IDX_W'(NUM_CH);
  localparam logic [DIV_W-1:0] DIV_RST_V    = DIV_W'(DIV_RST);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } seq_state_e;

  logic soft_clr;
`ifdef CLK_RST_GEN_SOFT_RST_EN
  assign soft_clr = soft_rst;
`else
  assign soft_clr = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Dividers
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]  div_cnt [NUM_CH];
  logic [DIV_W-1:0]  div_act [NUM_CH];
  logic [DIV_W-1:0]  div_shd [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wrap;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      wrap[k] = (div_cnt[k] == div_act[k]);
    end
  end

  // NOTE: these arrays are small flop banks, not RAM, so resetting every entry
  // is both legal and required for a defined divide ratio out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        div_cnt[k] <= '0;
        div_act[k] <= DIV_RST_V;
        div_shd[k] <= DIV_RST_V;
      end
      pending <= '0;
      clk_div <= '0;
      clk_stb <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every channel reading the pre-edge
      // values of pending/shadow, which is what makes same-edge loads defer.
      for (int k = 0; k < NUM_CH; k++) begin
        if (cfg_load) begin
          div_shd[k] <= div_cfg[k*DIV_W +: DIV_W];
        end
        if (en) begin
          if (wrap[k]) begin
            div_cnt[k] <= '0;
            clk_div[k] <= ~clk_div[k];
            clk_stb[k] <= ~clk_div[k];
            if (pending[k]) begin
              div_act[k] <= div_shd[k];
            end
          end else begin
            div_cnt[k] <= div_cnt[k] + 1'b1;
            clk_stb[k] <= 1'b0;
          end
        end else begin
          clk_stb[k] <= 1'b0;
        end
        // A load arriving on a wrap edge re-arms pending so it lands one wrap later.
        if (cfg_load) begin
          pending[k] <= 1'b1;
        end else if (en && wrap[k] && pending[k]) begin
          pending[k] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reset sequencer
  // ---------------------------------------------------------------------------
  seq_state_e       state_q, state_d;
  logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
  logic [IDX_W-1:0] rel_cnt_q, rel_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HOLD;
      seq_cnt_q <= '0;
      rel_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      seq_cnt_q <= seq_cnt_d;
      rel_cnt_q <= rel_cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    rel_cnt_d = rel_cnt_q;
    unique case (state_q)
      ST_HOLD: begin
        if (seq_cnt_q == HOLD_LAST) begin
          state_d   = ST_RELEASE;
          seq_cnt_d = '0;
          rel_cnt_d = IDX_W'(1);
        end else begin
          seq_cnt_d = seq_cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (rel_cnt_q == ALL_REL) begin
          state_d   = ST_DONE;
          seq_cnt_d = '0;
        end else if (seq_cnt_q == STAGGER_LAST) begin
          seq_cnt_d = '0;
          rel_cnt_d = rel_cnt_q + 1'b1;
        end else begin
          seq_cnt_d = seq_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase
    if (soft_clr) begin
      state_d   = ST_HOLD;
      seq_cnt_d = '0;
      rel_cnt_d = '0;
    end
  end

  // Channels are released in index order, so a count of released channels suffices.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      rstn_out[k] = (IDX_W'(k) < rel_cnt_q);
    end
  end

  assign rst_done = (state_q == ST_DONE);

endmodule
